// File: rtl/logic_analyzer_capture.sv
// logic_analyzer_capture
//
// Multi-channel logic-analyzer capture core. Probe inputs are synchronised,
// sampled at a programmable rate into a circular buffer that keeps
// PRE_TRIGGER samples of history, and capture stops DEPTH-PRE_TRIGGER-1
// samples after a masked level (or optional edge) trigger. On READ the buffer
// is streamed oldest-first to the UART transmitter, ceil(CHANNELS/8) bytes
// per sample, LSB byte first.
//
// Optional feature macro: LOGIC_ANALYZER_EDGE_TRIGGER_EN
//   defined     : MODE byte bit0 selects level (0) or edge (1) triggering.
//   not defined : MODE command is accepted and its byte discarded; the
//                 trigger is always level-sensitive.
//
// Ports:
//   clock                   : single rising-edge clock
//   reset_n                 : asynchronous active-low reset
//   dev_command_started     : one-cycle pulse, dev_command valid
//   dev_command[4:0]        : command code (ARM/MASK/VALUE/DIV/MODE/READ/ABORT)
//   dev_command_data_signal : one-cycle pulse, dev_data valid
//   dev_data[7:0]           : command argument byte
//   dev_busy                : high while streaming the buffer out
//   logic_in[CHANNELS-1:0]  : asynchronous probe inputs
//   uart_tx_send_byte       : one-cycle byte strobe to the UART transmitter
//   uart_tx_byte[7:0]       : byte to transmit
//   uart_tx_active          : UART transmitter busy flag
//   led_full                : high while a completed capture is held
//   state_out[2:0]          : current state for debug
module logic_analyzer_capture #(
  parameter int CHANNELS    = 6,
  parameter int DEPTH       = 1024,
  parameter int PRE_TRIGGER = 64,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                dev_command_started,
  input  logic [4:0]          dev_command,
  input  logic                dev_command_data_signal,
  input  logic [7:0]          dev_data,
  output logic                dev_busy,
  input  logic [CHANNELS-1:0] logic_in,
  output logic                uart_tx_send_byte,
  output logic [7:0]          uart_tx_byte,
  input  logic                uart_tx_active,
  output logic                led_full,
  output logic [2:0]          state_out
);

  localparam int AW  = $clog2(DEPTH);
  localparam int BPS = (CHANNELS + 7) / 8;
  localparam int BSW = (BPS > 1) ? $clog2(BPS) : 1;

  localparam logic [AW-1:0]  PRE_LAST  = AW'(PRE_TRIGGER - 1);
  localparam logic [AW-1:0]  POST_INIT = AW'(DEPTH - PRE_TRIGGER - 1);
  localparam logic [AW-1:0]  LAST_SMP  = AW'(DEPTH - 1);
  localparam logic [BSW-1:0] LAST_BYTE = BSW'(BPS - 1);

  localparam logic [4:0] CMD_ARM   = 5'h01;
  localparam logic [4:0] CMD_MASK  = 5'h02;
  localparam logic [4:0] CMD_VALUE = 5'h03;
  localparam logic [4:0] CMD_DIV   = 5'h04;
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
  localparam logic [4:0] CMD_MODE  = 5'h05;
`endif
  localparam logic [4:0] CMD_READ  = 5'h06;
  localparam logic [4:0] CMD_ABORT = 5'h07;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRETRIG   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_FULL      = 3'd4,
    S_READOUT   = 3'd5
  } state_t;

  // Readout sub-sequence for one byte / one sample.
  typedef enum logic [1:0] {
    P_ISSUE   = 2'd0,
    P_SEND    = 2'd1,
    P_WAIT_HI = 2'd2,
    P_WAIT_LO = 2'd3
  } phase_t;

  state_t state_q, state_d;
  phase_t phase_q, phase_d;

  logic [CHANNELS-1:0]  sync1_q, sync2_q;
  logic [4:0]           cmd_q, cmd_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [CHANNELS-1:0]  mask_q, mask_d;
  logic [CHANNELS-1:0]  value_q, value_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        count_q, count_d;
  logic [AW-1:0]        post_cnt_q, post_cnt_d;
  logic [AW-1:0]        rd_cnt_q, rd_cnt_d;
  logic [BSW-1:0]       byte_sel_q, byte_sel_d;
  logic                 send_q, send_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
  logic                 mode_q, mode_d;
  logic                 hit_prev_q, hit_prev_d;
`endif

  logic                 sample_stb;
  logic                 hit;
  logic                 trig;
  logic                 cmd_arm, cmd_read, cmd_abort;
  logic                 ram_we, ram_re;
  logic [AW-1:0]        ram_addr;
  logic [CHANNELS-1:0]  ram_rdata;
  logic [BPS*8-1:0]     padded;

  logic [CHANNELS-1:0]  mem [DEPTH];

  // Sample buffer: single port, registered read, no reset on contents.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem[ram_addr] <= sync2_q;
    end
    if (ram_re) begin
      ram_rdata <= mem[ram_addr];
    end
  end

  assign cmd_arm   = dev_command_started && (dev_command == CMD_ARM);
  assign cmd_read  = dev_command_started && (dev_command == CMD_READ);
  assign cmd_abort = dev_command_started && (dev_command == CMD_ABORT);

  // >= rather than == so that lowering div mid-capture cannot strand the
  // counter above the new terminal value.
  assign sample_stb = (div_cnt_q >= div_q);

  assign hit = (((sync2_q ^ value_q) & mask_q) == '0);
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
  assign trig = mode_q ? (hit && !hit_prev_q) : hit;
`else
  assign trig = hit;
`endif

  // Configuration registers and the argument byte index.
  always_comb begin
    cmd_d      = cmd_q;
    byte_idx_d = byte_idx_q;
    mask_d     = mask_q;
    value_d    = value_q;
    div_d      = div_q;
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
    mode_d     = mode_q;
`endif
    if (dev_command_started) begin
      cmd_d      = dev_command;
      byte_idx_d = 2'd0;
    end else if (dev_command_data_signal) begin
      // Saturate at 2: every command takes at most two bytes.
      if (byte_idx_q != 2'd2) begin
        byte_idx_d = byte_idx_q + 2'd1;
      end
      for (int i = 0; i < CHANNELS; i++) begin
        if (byte_idx_q == 2'(i / 8)) begin
          if (cmd_q == CMD_MASK) begin
            mask_d[i] = dev_data[i % 8];
          end
          if (cmd_q == CMD_VALUE) begin
            value_d[i] = dev_data[i % 8];
          end
        end
      end
      for (int i = 0; i < DIV_WIDTH; i++) begin
        if ((i < 16) && (cmd_q == CMD_DIV) && (byte_idx_q == 2'(i / 8))) begin
          div_d[i] = dev_data[i % 8];
        end
      end
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
      if ((cmd_q == CMD_MODE) && (byte_idx_q == 2'd0)) begin
        mode_d = dev_data[0];
      end
`endif
    end
  end

  // Zero-extend the read word so the byte selector never sees X bits.
  always_comb begin
    padded                 = '0;
    padded[CHANNELS-1:0]   = ram_rdata;
  end

  // Capture / readout state machine.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    byte_sel_d = byte_sel_q;
    send_d     = 1'b0;
    tx_byte_d  = tx_byte_q;
    div_cnt_d  = sample_stb ? '0 : div_cnt_q + 1'b1;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
    hit_prev_d = hit_prev_q;
`endif

    case (state_q)
      S_PRETRIG: begin
        if (sample_stb) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          count_d  = count_q + 1'b1;
          if (count_q == PRE_LAST) begin
            state_d = S_WAIT_TRIG;
          end
        end
      end
      S_WAIT_TRIG: begin
        if (sample_stb) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (trig) begin
            if (POST_INIT == '0) begin
              state_d = S_FULL;
            end else begin
              state_d    = S_POST;
              post_cnt_d = POST_INIT;
            end
          end
        end
      end
      S_POST: begin
        if (sample_stb) begin
          ram_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_q == AW'(1)) begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (cmd_read) begin
          // After the final write wr_ptr points at the oldest sample.
          state_d    = S_READOUT;
          phase_d    = P_ISSUE;
          rd_ptr_d   = wr_ptr_q;
          rd_cnt_d   = '0;
          byte_sel_d = '0;
        end
      end
      S_READOUT: begin
        case (phase_q)
          P_ISSUE: begin
            ram_re  = 1'b1;
            phase_d = P_SEND;
          end
          P_SEND: begin
            if (!uart_tx_active) begin
              send_d    = 1'b1;
              tx_byte_d = padded[{byte_sel_q, 3'b000} +: 8];
              phase_d   = P_WAIT_HI;
            end
          end
          P_WAIT_HI: begin
            if (uart_tx_active) begin
              phase_d = P_WAIT_LO;
            end
          end
          P_WAIT_LO: begin
            if (!uart_tx_active) begin
              if (byte_sel_q == LAST_BYTE) begin
                byte_sel_d = '0;
                if (rd_cnt_q == LAST_SMP) begin
                  state_d = S_FULL;
                  phase_d = P_ISSUE;
                end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  rd_cnt_d = rd_cnt_q + 1'b1;
                  phase_d  = P_ISSUE;
                end
              end else begin
                byte_sel_d = byte_sel_q + 1'b1;
                phase_d    = P_SEND;
              end
            end
          end
          default: phase_d = P_ISSUE;
        endcase
      end
      default: ;
    endcase

`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
    // hit_prev tracks every stored sample, including PRETRIG ones, so an
    // edge needs a non-hit sample inside the capture window.
    if (ram_we) begin
      hit_prev_d = hit;
    end
`endif

    // ARM restarts a capture from any state except an active readout.
    if (cmd_arm && (state_q != S_READOUT)) begin
      state_d   = (PRE_TRIGGER == 0) ? S_WAIT_TRIG : S_PRETRIG;
      wr_ptr_d  = '0;
      count_d   = '0;
      div_cnt_d = '0;
      ram_we    = 1'b0;
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
      hit_prev_d = 1'b1;
`endif
    end

    if (cmd_abort) begin
      state_d = S_IDLE;
      phase_d = P_ISSUE;
      send_d  = 1'b0;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
    end

    ram_addr = ram_we ? wr_ptr_q : rd_ptr_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      cmd_q      <= '0;
      byte_idx_q <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      div_q      <= '0;
      div_cnt_q  <= '0;
      state_q    <= S_IDLE;
      phase_q    <= P_ISSUE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      rd_cnt_q   <= '0;
      byte_sel_q <= '0;
      send_q     <= 1'b0;
      tx_byte_q  <= '0;
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
      mode_q     <= 1'b0;
      hit_prev_q <= 1'b1;
`endif
    end else begin
      sync1_q    <= logic_in;
      sync2_q    <= sync1_q;
      cmd_q      <= cmd_d;
      byte_idx_q <= byte_idx_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      byte_sel_q <= byte_sel_d;
      send_q     <= send_d;
      tx_byte_q  <= tx_byte_d;
`ifdef LOGIC_ANALYZER_EDGE_TRIGGER_EN
      mode_q     <= mode_d;
      hit_prev_q <= hit_prev_d;
`endif
    end
  end

  assign dev_busy          = (state_q == S_READOUT);
  assign led_full          = (state_q == S_FULL);
  assign state_out         = state_q;
  assign uart_tx_send_byte = send_q;
  assign uart_tx_byte      = tx_byte_q;

endmodule
